// File: rtl/dcache_port_ctrl_if.sv
// Port bundle between one dcache port controller and its surroundings.
// slave  : the controller itself (serves core requests, drives SRAM and miss-handler requests).
// master : the environment (core port, SRAM arbiter/tag compare, miss handler).
// Groups: core request/response, shared tag/data SRAM, miss handler / MSHR, uncached path.
interface dcache_port_ctrl_if #(
  parameter int unsigned WAYS     = 8,
  parameter int unsigned INDEX_W  = 12,
  parameter int unsigned TAG_W    = 44,
  parameter int unsigned LINE_W   = 128,
  parameter int unsigned OFFSET_W = 4
);
  // control / status
  logic                      bypass;
  logic                      stall;
  logic                      busy;
  // core request / response
  logic                      req_valid;
  logic [INDEX_W-1:0]        req_index;
  logic [TAG_W-1:0]          req_tag;
  logic                      req_tag_vld;
  logic                      req_kill;
  logic                      req_we;
  logic [63:0]               req_wdata;
  logic [7:0]                req_be;
  logic                      req_gnt;
  logic                      req_rvalid;
  logic [63:0]               req_rdata;
  // shared tag/data SRAM
  logic [WAYS-1:0]           sram_req;
  logic [INDEX_W-1:0]        sram_addr;
  logic                      sram_gnt;
  logic [TAG_W-1:0]          sram_tag;
  logic [WAYS*LINE_W-1:0]    sram_rdata;
  logic [WAYS-1:0]           sram_hit;
  logic                      sram_we;
  logic [LINE_W/8-1:0]       sram_be;
  logic [LINE_W-1:0]         sram_wdata;
  logic                      sram_valid;
  logic                      sram_dirty;
  // miss handler / MSHR
  logic                      miss_req;
  logic                      miss_byp;
  logic [TAG_W+INDEX_W-1:0]  miss_addr;
  logic                      miss_we;
  logic [63:0]               miss_wdata;
  logic [7:0]                miss_be;
  logic                      miss_gnt;
  logic                      mshr_match;
  // uncached path
  logic                      byp_gnt;
  logic                      byp_valid;
  logic [63:0]               byp_data;

  modport slave (
    input  bypass, stall, req_valid, req_index, req_tag, req_tag_vld, req_kill, req_we,
           req_wdata, req_be, sram_gnt, sram_rdata, sram_hit, miss_gnt, mshr_match,
           byp_gnt, byp_valid, byp_data,
    output busy, req_gnt, req_rvalid, req_rdata, sram_req, sram_addr, sram_tag, sram_we,
           sram_be, sram_wdata, sram_valid, sram_dirty, miss_req, miss_byp, miss_addr,
           miss_we, miss_wdata, miss_be
  );

  modport master (
    output bypass, stall, req_valid, req_index, req_tag, req_tag_vld, req_kill, req_we,
           req_wdata, req_be, sram_gnt, sram_rdata, sram_hit, miss_gnt, mshr_match,
           byp_gnt, byp_valid, byp_data,
    input  busy, req_gnt, req_rvalid, req_rdata, sram_req, sram_addr, sram_tag, sram_we,
           sram_be, sram_wdata, sram_valid, sram_dirty, miss_req, miss_byp, miss_addr,
           miss_we, miss_wdata, miss_be
  );
endinterface

// File: rtl/dcache_port_ctrl.sv
// Per-port L1 data-cache controller. Takes a core request (index first, tag later), arbitrates
// for the shared tag/data SRAM, returns load data on a hit, writes store data into the hit way,
// and hands misses / uncached accesses to the miss handler. One request outstanding at a time.
// Ports:
//   clk  - clock
//   clr  - synchronous active-high reset; drops any in-flight request
//   bus  - dcache_port_ctrl_if.slave: core request/response, SRAM, miss handler, uncached path
module dcache_port_ctrl #(
  parameter int unsigned WAYS     = 8,
  parameter int unsigned INDEX_W  = 12,
  parameter int unsigned TAG_W    = 44,
  parameter int unsigned LINE_W   = 128,
  parameter int unsigned OFFSET_W = 4
) (
  input logic               clk,
  input logic               clr,
  dcache_port_ctrl_if.slave bus
);

  localparam int unsigned WordW     = OFFSET_W - 3;
  localparam int unsigned LineBytes = LINE_W / 8;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitTag  = 3'd1;
  localparam logic [2:0] StLookup   = 3'd2;  // tag registered, SRAM data and hit valid
  localparam logic [2:0] StStore    = 3'd3;
  localparam logic [2:0] StWaitMshr = 3'd4;
  localparam logic [2:0] StMiss     = 3'd5;
  localparam logic [2:0] StBypData  = 3'd6;
  localparam logic [2:0] StReplay   = 3'd7;  // re-read SRAM for the latched request, no new gnt

  logic [2:0]         state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               we_q, we_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [7:0]         be_q, be_d;
  logic [WAYS-1:0]    hit_q, hit_d;
  logic               byp_q, byp_d;

  logic [WordW-1:0]     word_sel;
  logic [63:0]          hit_word;
  logic                 hit_any;
  logic [LineBytes-1:0] be_line;

  assign word_sel = index_q[OFFSET_W-1:3];
  assign hit_any  = |bus.sram_hit;
  assign be_line  = {{(LineBytes-8){1'b0}}, be_q} << (int'(word_sel) * 8);

  // AND-OR select of the addressed word from the one-hot hit way
  always_comb begin
    hit_word = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (bus.sram_hit[i]) begin
        hit_word = hit_word | bus.sram_rdata[i*LINE_W + int'(word_sel)*64 +: 64];
      end
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.sram_tag = tag_q;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tag_d   = tag_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    hit_d   = hit_q;
    byp_d   = byp_q;

    bus.req_gnt    = 1'b0;
    bus.req_rvalid = 1'b0;
    bus.req_rdata  = '0;
    bus.sram_req   = '0;
    bus.sram_addr  = '0;
    bus.sram_we    = 1'b0;
    bus.sram_be    = '0;
    bus.sram_wdata = '0;
    bus.sram_valid = 1'b0;
    bus.sram_dirty = 1'b0;
    bus.miss_req   = 1'b0;
    bus.miss_byp   = 1'b0;
    bus.miss_addr  = '0;
    bus.miss_we    = 1'b0;
    bus.miss_wdata = '0;
    bus.miss_be    = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && !bus.stall) begin
          bus.sram_req  = '1;
          bus.sram_addr = bus.req_index;
          if (bus.sram_gnt) begin
            bus.req_gnt = 1'b1;
            index_d     = bus.req_index;
            we_d        = bus.req_we;
            wdata_d     = bus.req_wdata;
            be_d        = bus.req_be;
            state_d     = StWaitTag;
          end
        end
      end
      StWaitTag: begin
        if (bus.req_kill) begin
          state_d = StIdle;
        end else if (bus.req_tag_vld) begin
          tag_d   = bus.req_tag;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (bus.bypass) begin
          byp_d   = 1'b1;
          state_d = StMiss;
        end else if (hit_any) begin
          if (we_q) begin
            hit_d   = bus.sram_hit;
            state_d = StStore;
          end else begin
            bus.req_rvalid = 1'b1;
            bus.req_rdata  = hit_word;
            state_d        = StIdle;
          end
        end else if (bus.mshr_match) begin
          state_d = StWaitMshr;
        end else begin
          byp_d   = 1'b0;
          state_d = StMiss;
        end
      end
      StStore: begin
        bus.sram_req   = hit_q;
        bus.sram_addr  = index_q;
        bus.sram_we    = 1'b1;
        bus.sram_be    = be_line;
        bus.sram_wdata = {(LINE_W/64){wdata_q}};
        bus.sram_valid = 1'b1;
        bus.sram_dirty = 1'b1;
        if (bus.sram_gnt) begin
          bus.req_rvalid = 1'b1;
          state_d        = StIdle;
        end
      end
      StWaitMshr: begin
        if (!bus.mshr_match) state_d = StReplay;
      end
      StMiss: begin
        bus.miss_req   = 1'b1;
        bus.miss_byp   = byp_q;
        bus.miss_addr  = {tag_q, index_q};
        bus.miss_we    = we_q;
        bus.miss_wdata = wdata_q;
        bus.miss_be    = be_q;
        if (byp_q) begin
          if (bus.byp_gnt) state_d = StBypData;
        end else if (bus.miss_gnt) begin
          state_d = StReplay;
        end
      end
      StBypData: begin
        if (bus.byp_valid) begin
          bus.req_rvalid = 1'b1;
          bus.req_rdata  = we_q ? 64'd0 : bus.byp_data;
          state_d        = StIdle;
        end
      end
      StReplay: begin
        bus.sram_req  = '1;
        bus.sram_addr = index_q;
        if (bus.sram_gnt) state_d = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      index_q <= '0;
      tag_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      hit_q   <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      hit_q   <= hit_d;
      byp_q   <= byp_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// Scoreboard bench for dcache_port_ctrl: stimulus pushes expected events, a negedge monitor
// pops and compares whenever the DUT presents gnt / rvalid / SRAM write / new miss request.
module tb_dcache_port_ctrl;
  localparam int unsigned WAYS     = 8;
  localparam int unsigned INDEX_W  = 12;
  localparam int unsigned TAG_W    = 44;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;

  localparam int KGnt  = 0;
  localparam int KRv   = 1;
  localparam int KSwr  = 2;
  localparam int KMiss = 3;

  typedef struct {
    int           kind;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    bit           chk;
  } exp_t;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];
  logic miss_prev;

  dcache_port_ctrl_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W),
                        .OFFSET_W(OFFSET_W)) bus ();

  dcache_port_ctrl #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W),
                     .OFFSET_W(OFFSET_W)) dut (.clk(clk), .clr(clr), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] c, input bit chk);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c; e.chk = chk;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] c);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected no event", kind);
      return;
    end
    e = q.pop_front();
    check("event_kind", 128'(kind), 128'(e.kind));
    if (e.kind == kind) begin
      case (kind)
        KRv:  if (e.chk) check("req_rdata", a, e.a);
        KSwr: begin
          check("sram_be", a, e.a);
          check("sram_wdata", b, e.b);
          check("sram_dirty_valid_req", c, e.c);
        end
        KMiss: begin
          check("miss_addr", a, e.a);
          check("miss_byp", b, e.b);
        end
        default: ;
      endcase
    end
  endtask

  // monitor: pops one expectation per DUT-presented event
  always @(negedge clk) begin
    if (bus.sram_we && bus.sram_gnt)
      expect_ev(KSwr, 128'(bus.sram_be), 128'(bus.sram_wdata),
                128'({bus.sram_dirty, bus.sram_valid, bus.sram_req}));
    if (bus.req_gnt) expect_ev(KGnt, '0, '0, '0);
    if (bus.req_rvalid) expect_ev(KRv, 128'(bus.req_rdata), '0, '0);
    if (bus.miss_req && !miss_prev)
      expect_ev(KMiss, 128'(bus.miss_addr), 128'(bus.miss_byp), '0);
    miss_prev <= bus.miss_req;
  end

  task automatic do_req(input logic [11:0] idx, input logic we, input logic [63:0] wd,
                        input logic [7:0] be);
    bit got;
    got = 1'b0;
    bus.req_valid = 1'b1; bus.req_index = idx; bus.req_we = we;
    bus.req_wdata = wd;   bus.req_be = be;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_gnt) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (got) begin @(posedge clk); #1; end
    bus.req_valid = 1'b0;
    if (!got) begin n_cmp++; n_bad++; $display("FAIL gnt_timeout: got none expected req_gnt"); end
  endtask

  task automatic send_tag(input logic [43:0] tag, input logic kill);
    bus.req_tag = tag; bus.req_tag_vld = 1'b1; bus.req_kill = kill;
    @(posedge clk); #1;
    bus.req_tag_vld = 1'b0; bus.req_kill = 1'b0;
  endtask

  task automatic wait_miss();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.miss_req) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!got) begin n_cmp++; n_bad++; $display("FAIL miss_timeout: got none expected miss_req"); end
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!got) begin n_cmp++; n_bad++; $display("FAIL idle_timeout: got busy expected idle"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0] t1, t2, t3, t4;
    logic [63:0] wd;
    t1 = 44'h123_4567_89AB;
    t2 = 44'hABC_DEF0_1234;
    t3 = 44'h0F0_F0F0_F0F0;
    t4 = 44'h777_0000_1111;
    wd = 64'h0123_4567_89AB_CDEF;
    n_cmp = 0; n_bad = 0; miss_prev = 1'b0;
    clr = 1'b1;
    bus.bypass = 0; bus.stall = 0; bus.req_valid = 0; bus.req_index = '0; bus.req_tag = '0;
    bus.req_tag_vld = 0; bus.req_kill = 0; bus.req_we = 0; bus.req_wdata = '0; bus.req_be = '0;
    bus.sram_gnt = 1; bus.sram_rdata = '0; bus.sram_hit = '0; bus.miss_gnt = 0;
    bus.mshr_match = 0; bus.byp_gnt = 0; bus.byp_valid = 0; bus.byp_data = '0;
    repeat (2) @(posedge clk); #1;

    // reset state
    @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_req_gnt", 128'(bus.req_gnt), 128'(0));
    check("rst_rvalid", 128'(bus.req_rvalid), 128'(0));
    check("rst_sram_req", 128'(bus.sram_req), 128'(0));
    check("rst_sram_tag", 128'(bus.sram_tag), 128'(0));
    check("rst_miss_req", 128'(bus.miss_req), 128'(0));
    @(posedge clk); #1;
    clr = 1'b0;

    // hit load: way3 word1
    bus.sram_rdata[3*128 +: 64] = 64'h1111_1111_1111_1111;
    bus.sram_rdata[3*128+64 +: 64] = 64'hDEAD_BEEF;
    bus.sram_rdata[2*128+64 +: 64] = 64'h2222_2222_2222_2222;
    bus.sram_hit = 8'h08;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KRv, 128'(64'hDEAD_BEEF), '0, '0, 1'b1);
    do_req(12'h018, 1'b0, '0, '0);
    send_tag(t1, 1'b0);
    wait_idle();

    // hit load: way7 word0
    bus.sram_rdata[7*128 +: 64] = 64'h0011_2233_4455_6677;
    bus.sram_rdata[7*128+64 +: 64] = 64'h9999_8888_7777_6666;
    bus.sram_hit = 8'h80;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KRv, 128'(64'h0011_2233_4455_6677), '0, '0, 1'b1);
    do_req(12'h000, 1'b0, '0, '0);
    send_tag(t2, 1'b0);
    wait_idle();

    // stall holds off the grant
    bus.stall = 1'b1; bus.req_valid = 1'b1; bus.req_index = 12'h100;
    repeat (3) begin
      @(negedge clk);
      check("stall_no_gnt", 128'(bus.req_gnt), 128'(0));
      check("stall_no_sram_req", 128'(bus.sram_req), 128'(0));
    end
    @(posedge clk); #1;
    bus.stall = 1'b0;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KRv, 128'(64'h0011_2233_4455_6677), '0, '0, 1'b1);
    do_req(12'h100, 1'b0, '0, '0);
    send_tag(t1, 1'b0);
    wait_idle();

    // hit store: way0, idx 0x008 -> word1, be 0x0F -> 0x0F00
    bus.sram_hit = 8'h01;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KSwr, 128'(16'h0F00), {wd, wd}, 128'(10'h301), 1'b1);
    push(KRv, '0, '0, '0, 1'b0);
    do_req(12'h008, 1'b1, wd, 8'h0F);
    bus.sram_gnt = 1'b0;
    send_tag(t1, 1'b0);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("store_hold_we", 128'(bus.sram_we), 128'(1));
      check("store_hold_no_rvalid", 128'(bus.req_rvalid), 128'(0));
    end
    @(posedge clk); #1;
    bus.sram_gnt = 1'b1;
    wait_idle();

    // cached miss then refill replay
    bus.sram_hit = 8'h00;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KMiss, 128'({t2, 12'h010}), 128'(0), '0, 1'b1);
    push(KRv, 128'(64'hCAFE_F00D_1234_5678), '0, '0, 1'b1);
    do_req(12'h010, 1'b0, '0, '0);
    send_tag(t2, 1'b0);
    wait_miss();
    bus.sram_rdata[5*128 +: 64] = 64'hCAFE_F00D_1234_5678;
    bus.sram_hit = 8'h20;
    bus.miss_gnt = 1'b1;
    @(posedge clk); #1;
    bus.miss_gnt = 1'b0;
    wait_idle();

    // bypass load: hit is ignored
    bus.bypass = 1'b1;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KMiss, 128'({t3, 12'h020}), 128'(1), '0, 1'b1);
    push(KRv, 128'(64'h1234), '0, '0, 1'b1);
    do_req(12'h020, 1'b0, '0, '0);
    send_tag(t3, 1'b0);
    wait_miss();
    bus.byp_gnt = 1'b1;
    @(posedge clk); #1;
    bus.byp_gnt = 1'b0;
    @(posedge clk); #1;
    bus.byp_valid = 1'b1; bus.byp_data = 64'h1234;
    @(posedge clk); #1;
    bus.byp_valid = 1'b0;
    wait_idle();
    bus.bypass = 1'b0;

    // MSHR conflict: no miss request while match held
    bus.sram_hit = 8'h00;
    bus.mshr_match = 1'b1;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KMiss, 128'({t4, 12'h030}), 128'(0), '0, 1'b1);
    push(KRv, 128'(64'h5555_AAAA_0F0F_F0F0), '0, '0, 1'b1);
    do_req(12'h030, 1'b0, '0, '0);
    send_tag(t4, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("mshr_no_miss", 128'(bus.miss_req), 128'(0));
    end
    @(posedge clk); #1;
    bus.mshr_match = 1'b0;
    wait_miss();
    bus.sram_rdata[2*128 +: 64] = 64'h5555_AAAA_0F0F_F0F0;
    bus.sram_hit = 8'h04;
    bus.miss_gnt = 1'b1;
    @(posedge clk); #1;
    bus.miss_gnt = 1'b0;
    wait_idle();

    // kill together with tag valid: kill wins, no rvalid
    push(KGnt, '0, '0, '0, 1'b0);
    do_req(12'h040, 1'b0, '0, '0);
    send_tag(t1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("kill_idle", 128'(bus.busy), 128'(0));
    end
    check("kill_queue_empty", 128'(q.size()), 128'(0));
    @(posedge clk); #1;

    // clr during MISS drops the request
    bus.sram_hit = 8'h00;
    push(KGnt, '0, '0, '0, 1'b0);
    push(KMiss, 128'({t2, 12'h050}), 128'(0), '0, 1'b1);
    do_req(12'h050, 1'b0, '0, '0);
    send_tag(t2, 1'b0);
    wait_miss();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_busy", 128'(bus.busy), 128'(0));
    check("clr_miss_req", 128'(bus.miss_req), 128'(0));
    check("clr_miss_addr", 128'(bus.miss_addr), 128'(0));
    check("clr_sram_req", 128'(bus.sram_req), 128'(0));
    check("clr_sram_tag", 128'(bus.sram_tag), 128'(0));
    check("clr_rvalid", 128'(bus.req_rvalid), 128'(0));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    check("final_queue_empty", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
